// File: rtl/irq_ctrl_pkg.sv
// Shared FSM states, register offsets, CAUSE codes and CTRL bit positions for irq_ctrl.
// IRQ_CTRL_EXT_IRQ_EN selects whether the external source exists (SRC_MASK).
package irq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_IP   = 4'h4;
    localparam logic [3:0] OFF_VEC  = 4'h8;
    localparam logic [3:0] OFF_EPC  = 4'hC;

    localparam logic CAUSE_TIMER = 1'b0;
    localparam logic CAUSE_EXT   = 1'b1;

    localparam int CTRL_GIE   = 31;
    localparam int CTRL_PGIE  = 30;
    localparam int CTRL_CAUSE = 8;

`ifdef IRQ_CTRL_EXT_IRQ_EN
    localparam logic [1:0] SRC_MASK = 2'b11;
`else
    localparam logic [1:0] SRC_MASK = 2'b01;
`endif

    function automatic logic [31:0] ctrl_word(input logic gie, input logic pgie,
                                              input logic cause, input logic [1:0] ie);
        logic [31:0] w;
        w             = 32'd0;
        w[CTRL_GIE]   = gie;
        w[CTRL_PGIE]  = pgie;
        w[CTRL_CAUSE] = cause;
        w[1:0]        = ie;
        return w;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Fetch/CPU-facing signal bundle of irq_ctrl; slave = controller side, master = CPU side.
// No backpressure: irq_req is held until irq_ack, register strobes are always accepted.
interface irq_ctrl_if;
    logic        timer_interrupt;
    logic        ext_irq;
    logic        irq_req;
    logic        irq_ack;
    logic [31:0] current_pc;
    logic [31:0] irq_vector;
    logic        mret;
    logic [31:0] epc_out;
    logic        irq_active;
    logic        reg_we;
    logic        reg_re;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    modport slave (
        input  timer_interrupt, ext_irq, irq_ack, current_pc, mret,
               reg_we, reg_re, reg_addr, reg_wdata,
        output irq_req, irq_vector, epc_out, irq_active, reg_rdata
    );

    modport master (
        output timer_interrupt, ext_irq, irq_ack, current_pc, mret,
               reg_we, reg_re, reg_addr, reg_wdata,
        input  irq_req, irq_vector, epc_out, irq_active, reg_rdata
    );
endinterface

// File: rtl/irq_edge_det.sv
// Rising-edge detector with optional 2-flop synchronizer (SYNC=1 adds 2 cycles of latency).
// No backpressure: o_rise is a single-cycle pulse.
module irq_edge_det #(
    parameter bit SYNC = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic w_sig;
    logic r_prev;

    generate
        if (SYNC) begin : g_sync
            logic [1:0] r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= 2'b00;
                else        r_sync <= {r_sync[0], i_sig};
            end
            assign w_sig = r_sync[1];
        end else begin : g_direct
            assign w_sig = i_sig;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b0;
        else        r_prev <= w_sig;
    end

    assign o_rise = w_sig & ~r_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Single-level interrupt controller: IP/IE/GIE gating, IDLE->REQ->ACTIVE handshake with fetch, EPC save.
// Edge to irq_req is 2 cycles (timer) / 4 cycles (external, IRQ_CTRL_EXT_IRQ_EN); irq_req holds until irq_ack.
module irq_ctrl
    import irq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    irq_ctrl_if.slave  irq_bus
);

    logic [1:0]  r_state;
    logic        r_req;
    logic        r_cause;
    logic        r_gie;
    logic        r_pgie;
    logic [1:0]  r_ie;
    logic [1:0]  r_ip;
    logic [29:0] r_vec;
    logic [31:0] r_epc;
    logic [31:0] r_rdata;

    logic        w_tmr_rise;
    logic        w_ext_rise;
    logic [1:0]  w_pend;
    logic        w_ctrl_wr;
    logic        w_ip_wr;
    logic        w_vec_wr;
    logic        w_ack_take;
    logic        w_mret_take;
    logic [1:0]  w_ack_clr;
    logic [1:0]  w_w1c;
    logic [1:0]  w_ip_nxt;
    logic [31:0] w_rdata_mux;

    irq_edge_det #(.SYNC(1'b0)) u_tmr_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (irq_bus.timer_interrupt),
        .o_rise (w_tmr_rise)
    );

`ifdef IRQ_CTRL_EXT_IRQ_EN
    irq_edge_det #(.SYNC(1'b1)) u_ext_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (irq_bus.ext_irq),
        .o_rise (w_ext_rise)
    );
`else
    logic w_unused_ext;
    assign w_unused_ext = irq_bus.ext_irq;
    assign w_ext_rise   = 1'b0;
`endif

    assign w_pend      = r_ip & r_ie;
    assign w_ctrl_wr   = irq_bus.reg_we && (irq_bus.reg_addr == OFF_CTRL);
    assign w_ip_wr     = irq_bus.reg_we && (irq_bus.reg_addr == OFF_IP);
    assign w_vec_wr    = irq_bus.reg_we && (irq_bus.reg_addr == OFF_VEC);
    assign w_ack_take  = (r_state == ST_REQ) && irq_bus.irq_ack;
    assign w_mret_take = (r_state == ST_ACTIVE) && irq_bus.mret;
    assign w_ack_clr   = w_ack_take ? (2'b01 << r_cause) : 2'b00;
    assign w_w1c       = w_ip_wr ? irq_bus.reg_wdata[1:0] : 2'b00;
    // New edges are OR-ed in last so they survive both the W1C and the ack clear.
    assign w_ip_nxt    = ((r_ip & ~(w_ack_clr | w_w1c)) | {w_ext_rise, w_tmr_rise}) & SRC_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_cause <= CAUSE_TIMER;
            r_epc   <= 32'd0;
            r_pgie  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_gie && (|w_pend)) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_cause <= w_pend[0] ? CAUSE_TIMER : CAUSE_EXT;
                    end
                end
                ST_REQ: begin
                    if (w_ack_take) begin
                        r_state <= ST_ACTIVE;
                        r_req   <= 1'b0;
                        r_epc   <= irq_bus.current_pc;
                        r_pgie  <= r_gie;
                    end
                end
                ST_ACTIVE: begin
                    if (w_mret_take) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Hardware GIE updates take priority over a CPU write in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gie   <= 1'b0;
            r_ie    <= 2'b00;
            r_ip    <= 2'b00;
            r_vec   <= 30'd0;
            r_rdata <= 32'd0;
        end else begin
            if (w_ack_take)       r_gie <= 1'b0;
            else if (w_mret_take) r_gie <= r_pgie;
            else if (w_ctrl_wr)   r_gie <= irq_bus.reg_wdata[CTRL_GIE];
            if (w_ctrl_wr) r_ie  <= irq_bus.reg_wdata[1:0] & SRC_MASK;
            if (w_vec_wr)  r_vec <= irq_bus.reg_wdata[31:2];
            r_ip <= w_ip_nxt;
            if (irq_bus.reg_re) r_rdata <= w_rdata_mux;
        end
    end

    always_comb begin
        w_rdata_mux = 32'd0;
        case (irq_bus.reg_addr)
            OFF_CTRL: w_rdata_mux = ctrl_word(r_gie, r_pgie, r_cause, r_ie);
            OFF_IP:   w_rdata_mux = {30'd0, r_ip};
            OFF_VEC:  w_rdata_mux = {r_vec, 2'b00};
            OFF_EPC:  w_rdata_mux = r_epc;
            default:  w_rdata_mux = 32'd0;
        endcase
    end

    assign irq_bus.irq_req    = r_req;
    assign irq_bus.irq_vector = {r_vec, 2'b00} + {29'd0, r_cause, 2'b00};
    assign irq_bus.epc_out    = r_epc;
    assign irq_bus.irq_active = (r_state == ST_ACTIVE);
    assign irq_bus.reg_rdata  = r_rdata;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 clk  in  1  single core clock; all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 timer_interrupt  in  1  timer done pulse/level, synchronous to clk.
REQ-004 ext_irq  in  1  external interrupt line, asynchronous to clk.
REQ-005 irq_req  out  1  registered request to instruction fetch.
REQ-006 irq_ack  in  1  fetch accepts redirect this cycle.
REQ-007 current_pc  in  32  return PC presented with irq_ack.
REQ-008 irq_vector  out  32  handler address, valid while irq_req=1.
REQ-009 mret  in  1  one-cycle pulse: handler return.
REQ-010 epc_out  out  32  saved return PC, the mret target.
REQ-011 irq_active  out  1  handler in progress.
REQ-012 reg_we, reg_re  in  1 each  register write and read strobes.
REQ-013 reg_addr  in  4  byte offset: 0x0 CTRL, 0x4 IP, 0x8 VEC, 0xC EPC.
REQ-014 reg_wdata  in  32  write data.
REQ-015 reg_rdata  out  32  read data.

Function
REQ-016 CTRL register layout:
  - bit31 GIE (global enable)
  - bit30 PGIE (read-only)
  - bits9:8 CAUSE (read-only): 0 = timer, 1 = external
  - bits1:0 IE (per-source enables)
REQ-017 IP register: a rising edge on a source sets its bit; writing 1 to a bit clears it; writing 0 has no effect.
REQ-018 When a source edge and a W1C clear hit the same IP bit in the same cycle, the set wins.
REQ-019 VEC register: read/write; bits1:0 always read 0. EPC register: read-only; writes are ignored.
REQ-020 Register reads have 1-cycle latency; reg_rdata holds its value when reg_re=0; unmapped offsets read 0.
REQ-021 FSM has three states: IDLE, REQ and ACTIVE.
REQ-022 IDLE -> REQ when GIE and (IP & IE) != 0; in the same edge, latch CAUSE, with timer priority over external.
REQ-023 irq_vector = VEC + (CAUSE << 2).
REQ-024 REQ -> ACTIVE on irq_ack. In that edge:
  - EPC <= current_pc
  - PGIE <= GIE, GIE <= 0
  - the serviced IP bit is cleared
  - irq_req drops
REQ-025 In REQ, irq_req stays 1 and CAUSE stays frozen until irq_ack, even if IE or GIE changes.
REQ-026 ACTIVE -> IDLE on mret; GIE <= PGIE in that edge. irq_active=1 only in ACTIVE.
REQ-027 irq_ack outside REQ and mret outside ACTIVE are ignored.
REQ-028 A hardware GIE update (ack or mret) overrides a CPU CTRL write in the same cycle; the IE bits from that write still apply.
REQ-029 Latency from a timer_interrupt edge sampled at clock edge k:
  - IP[0]=1 after edge k
  - irq_req=1 after edge k+1
  - ext_irq takes 2 additional cycles (synchronizer).
REQ-030 Nesting is not supported. Edges during ACTIVE set IP and are serviced after mret.

Reset
REQ-031 While reset=0, asynchronously:
  - state = IDLE
  - irq_req, irq_active = 0
  - irq_vector, epc_out, reg_rdata = 0
  - GIE, PGIE, IE, IP, CAUSE, VEC, EPC = 0
  - synchronizer and edge-detect history = 0
REQ-032 Reset asserted mid-REQ or mid-ACTIVE abandons the interrupt; after release the block does not request until a new edge arrives.

Configuration
REQ-033 With IRQ_CTRL_EXT_IRQ_EN defined, the external source, its synchronizer, IE[1] and IP[1] are present.
REQ-034 Without IRQ_CTRL_EXT_IRQ_EN:
  - ext_irq is ignored
  - IE[1] and IP[1] read 0 and are not writable
  - CAUSE is always 0

Structure
REQ-035 irq_ctrl_pkg holds the FSM state enum, register offset constants, CAUSE codes and CTRL bit positions.
REQ-036 Sub-module irq_edge_det (optional 2-flop synchronizer plus rising-edge detector) is instantiated once per source.

Verification
REQ-037 Reset, GIE=1, IE=01, VEC=0x100, timer pulse at edge 10:
  - irq_req=1 after edge 11
  - irq_vector=0x100
  - ack with current_pc=0x40 -> EPC=0x40, GIE=0, IP=00
REQ-038 Timer and external edges in the same cycle, IE=11:
  - timer serviced first
  - after mret, ext serviced at vector VEC+4 with CAUSE=1
REQ-039 Timer edge during ACTIVE:
  - IP[0]=1, no irq_req
  - mret -> GIE restored to 1, irq_req 2 cycles later
REQ-040 W1C to IP[0] in the same cycle as a timer edge -> IP[0]=1; W1C with IP[0]=1 and no edge -> IP[0]=0, no request.
REQ-041 reset=0 while in REQ -> irq_req=0 immediately; after release with IP=0 no request; a CTRL read returns 0.
REQ-042 Built without IRQ_CTRL_EXT_IRQ_EN: ext_irq toggling, IE written 0x3 -> IE and IP read 0x1/0x0 and no request.
